// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: Moore outputs per state, with mem_ready-qualified fetch and branch strobes.
// Memory waits stall in FETCH/MEMRD/MEMWR until mem_ready; an unsupported opcode parks in HALT until reset.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
    end
  end

  // DECODE steers on the live opcode while capturing it; later states see only opcode_q.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode_q == OP_LW)      state_d = S_MEMRD;
        else if (opcode_q == OP_SW) state_d = S_MEMWR;
        else                        state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // While reset is held the datapath sees an idle fetch, whatever state_q currently is.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    if (reset) begin
      mem_read  = 1'b1;
      alu_src_b = 2'b01;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_source = 2'b01;
          pc_write  = ((opcode_q == OP_BEQ) && zero) || ((opcode_q == OP_BNE) && !zero);
        end
        S_JUMP: begin
          pc_source = 2'b10;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each driven cycle queues its expected output word; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // strobes order: pc_write ir_write mem_read mem_write i_or_d reg_write reg_dst mem_to_reg alu_src_a
  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic [8:0] stb;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] pcs;
  } exp_t;

  typedef struct {
    exp_t  e;
    exp_t  m;
    string name;
  } item_t;

  localparam exp_t E_FETCH_W = {4'd0,  1'b0, 9'b001000000, 2'b01, 2'b00, 2'b00};
  localparam exp_t E_FETCH_R = {4'd0,  1'b0, 9'b111000000, 2'b01, 2'b00, 2'b00};
  localparam exp_t E_DEC     = {4'd1,  1'b0, 9'b000000000, 2'b11, 2'b00, 2'b00};
  localparam exp_t E_MADR    = {4'd2,  1'b0, 9'b000000001, 2'b10, 2'b00, 2'b00};
  localparam exp_t E_MRD     = {4'd3,  1'b0, 9'b001010000, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_MWB     = {4'd4,  1'b0, 9'b000001010, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_MWR     = {4'd5,  1'b0, 9'b000110000, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_EXEC    = {4'd6,  1'b0, 9'b000000001, 2'b00, 2'b10, 2'b00};
  localparam exp_t E_RWB     = {4'd7,  1'b0, 9'b000001100, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_BR      = {4'd8,  1'b0, 9'b000000001, 2'b00, 2'b01, 2'b01};
  localparam exp_t E_BR_T    = {4'd8,  1'b0, 9'b100000001, 2'b00, 2'b01, 2'b01};
  localparam exp_t E_JMP     = {4'd9,  1'b0, 9'b100000000, 2'b00, 2'b00, 2'b10};
  localparam exp_t E_HALT    = {4'd10, 1'b1, 9'b000000000, 2'b00, 2'b00, 2'b00};
  localparam exp_t M_ALL     = {5'b11111, 15'h7FFF};
  localparam exp_t M_STB     = {5'b00000, 15'h7FFF};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010, BAD = 6'b111111;

  item_t sb[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                      input exp_t e, input exp_t m, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    reset = r; opcode = op; zero = z; mem_ready = mr;
    it.e = e; it.m = m; it.name = nm;
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    exp_t  act;
    item_t it;
    act = {state, illegal, pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
    if (sb.size() > 0) begin
      it = sb.pop_front();
      n_chk++;
      if (((act ^ it.e) & it.m) != '0) begin
        n_fail++;
        $display("FAIL %s: got st=%0d ill=%b stb=%b asb=%b aop=%b pcs=%b, want st=%0d ill=%b stb=%b asb=%b aop=%b pcs=%b",
                 it.name, act.st, act.ill, act.stb, act.asb, act.aop, act.pcs,
                 it.e.st, it.e.ill, it.e.stb, it.e.asb, it.e.aop, it.e.pcs);
      end
      n_chk++;
      if (32'(mem_read) + 32'(mem_write) + 32'(reg_write) > 1) begin
        n_fail++;
        $display("FAIL exclusive_strobes: got rd=%b wr=%b rw=%b, want at most one high",
                 mem_read, mem_write, reg_write);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, RT, 0, 0, E_FETCH_W, M_ALL, "reset");
    // lw, mem_ready high throughout
    step(0, LW, 0, 1, E_FETCH_R, M_ALL, "lw_fetch");
    step(0, LW, 0, 1, E_DEC,     M_ALL, "lw_dec");
    step(0, LW, 0, 1, E_MADR,    M_ALL, "lw_madr");
    step(0, LW, 0, 1, E_MRD,     M_ALL, "lw_mrd");
    step(0, LW, 0, 1, E_MWB,     M_ALL, "lw_mwb");
    step(0, LW, 0, 0, E_FETCH_W, M_ALL, "lw_back");
    // sw with three wait cycles; opcode input changed after capture
    step(0, SW, 0, 1, E_FETCH_R, M_ALL, "sw_fetch");
    step(0, SW, 0, 0, E_DEC,     M_ALL, "sw_dec");
    step(0, LW, 0, 0, E_MADR,    M_ALL, "sw_madr");
    step(0, LW, 0, 0, E_MWR,     M_ALL, "sw_wait1");
    step(0, LW, 0, 0, E_MWR,     M_ALL, "sw_wait2");
    step(0, LW, 0, 0, E_MWR,     M_ALL, "sw_wait3");
    step(0, LW, 0, 1, E_MWR,     M_ALL, "sw_done");
    step(0, RT, 0, 0, E_FETCH_W, M_ALL, "sw_back");
    // R-type
    step(0, RT, 0, 1, E_FETCH_R, M_ALL, "r_fetch");
    step(0, RT, 0, 0, E_DEC,     M_ALL, "r_dec");
    step(0, BAD, 0, 1, E_EXEC,   M_ALL, "r_exec");
    step(0, BAD, 0, 1, E_RWB,    M_ALL, "r_rwb");
    step(0, BEQ, 0, 1, E_FETCH_R, M_ALL, "r_back");
    // beq taken, live opcode swapped to bne in the branch cycle
    step(0, BEQ, 0, 0, E_DEC,    M_ALL, "beq_dec");
    step(0, BNE, 1, 0, E_BR_T,   M_ALL, "beq_z1");
    step(0, BEQ, 0, 1, E_FETCH_R, M_ALL, "beq_fetch");
    step(0, BEQ, 0, 0, E_DEC,    M_ALL, "beq_dec2");
    step(0, BEQ, 0, 0, E_BR,     M_ALL, "beq_z0");
    step(0, BNE, 0, 1, E_FETCH_R, M_ALL, "bne_fetch");
    step(0, BNE, 0, 0, E_DEC,    M_ALL, "bne_dec");
    step(0, BEQ, 1, 0, E_BR,     M_ALL, "bne_z1");
    step(0, BNE, 0, 1, E_FETCH_R, M_ALL, "bne_fetch2");
    step(0, BNE, 0, 0, E_DEC,    M_ALL, "bne_dec2");
    step(0, BNE, 0, 0, E_BR_T,   M_ALL, "bne_z0");
    // jump
    step(0, JMP, 0, 1, E_FETCH_R, M_ALL, "j_fetch");
    step(0, JMP, 0, 0, E_DEC,    M_ALL, "j_dec");
    step(0, JMP, 0, 0, E_JMP,    M_ALL, "j_jump");
    step(0, BAD, 0, 1, E_FETCH_R, M_ALL, "bad_fetch");
    // illegal opcode parks in HALT
    step(0, BAD, 0, 1, E_DEC,    M_ALL, "bad_dec");
    for (int i = 0; i < 12; i++)
      step(0, LW, i[0], i[1], E_HALT, M_ALL, "halt_hold");
    step(1, LW, 0, 1, E_FETCH_W, M_STB, "halt_rst_out");
    step(0, LW, 0, 0, E_FETCH_W, M_ALL, "halt_rst");
    // reset in the middle of a stalled read
    step(0, LW, 0, 1, E_FETCH_R, M_ALL, "rl_fetch");
    step(0, LW, 0, 1, E_DEC,     M_ALL, "rl_dec");
    step(0, LW, 0, 0, E_MADR,    M_ALL, "rl_madr");
    step(0, LW, 0, 0, E_MRD,     M_ALL, "rl_mrd_wait");
    step(1, LW, 0, 0, E_FETCH_W, M_STB, "rl_rst_out");
    step(0, LW, 0, 0, E_FETCH_W, M_ALL, "rl_after");
    step(0, LW, 0, 1, E_FETCH_R, M_ALL, "rl_fetch2");
    step(0, LW, 0, 0, E_DEC,     M_ALL, "rl_dec2");
    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
- REQ-001 SHALL have no parameters; opcodes and state codes are fixed by this spec.
- REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
- REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- REQ-004 opcode  input  6  instruction opcode field from the instruction register.
- REQ-005 zero  input  1  ALU zero flag.
- REQ-006 mem_ready  input  1  memory handshake; high means the current access completes this cycle.
- REQ-007 pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes and mux selects.
- REQ-008 alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- REQ-009 alu_op  output  2  code to the ALU-control decoder: 00 = add (lw/sw/PC increment), 01 = subtract (beq/bne), 10 = use the function field (R-type).
- REQ-010 pc_source  output  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- REQ-011 state  output  4  current state code, for debug.
- REQ-012 illegal  output  1  sticky flag: an unsupported opcode was decoded.

Function
- REQ-013 States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, HALT=10; codes 11-15 SHALL go to FETCH on the next edge.
- REQ-014 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- REQ-015 In DECODE, opcode SHALL be captured into an internal register; all later states use only the captured value.
- REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=1 and pc_write=1 only in a cycle where mem_ready=1; stay in FETCH while mem_ready=0, go to DECODE when mem_ready=1.
- REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: lw/sw to MEMADR, R-type to EXEC, beq/bne to BRANCH, j to JUMP, any other opcode to HALT with illegal set.
- REQ-018 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw goes to MEMRD, sw goes to MEMWR.
- REQ-019 MEMRD: mem_read=1, i_or_d=1; hold while mem_ready=0; go to MEMWB when mem_ready=1.
- REQ-020 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
- REQ-021 MEMWR: mem_write=1, i_or_d=1; hold while mem_ready=0; go to FETCH when mem_ready=1; mem_write SHALL stay high for every held cycle.
- REQ-022 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then RWB.
- REQ-023 RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write = (beq and zero) or (bne and not zero), evaluated combinationally in that cycle; then FETCH.
- REQ-025 JUMP: pc_source=10, pc_write=1; then FETCH.
- REQ-026 HALT SHALL be absorbing until reset; all strobes are 0 in HALT.
- REQ-027 Any output not listed for a state SHALL be 0; outputs other than the mem_ready-qualified strobes SHALL depend only on the state (Moore).
- REQ-028 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.
- REQ-029 No two of mem_read, mem_write and reg_write SHALL be high in the same cycle.

Reset
- REQ-030 reset=1 at an edge SHALL force state=FETCH, clear illegal and clear the captured opcode, regardless of the current state or a pending memory wait.
- REQ-031 While reset is high, outputs SHALL show the FETCH values with pc_write=0 and ir_write=0.
- REQ-032 Reset SHALL take priority over every transition, including leaving HALT.

Verification
- REQ-033 lw with mem_ready=1 throughout -> state sequence 0,1,2,3,4,0 (5 cycles); reg_write=1 and mem_to_reg=1 only in state 4.
- REQ-034 sw with mem_ready low for 3 cycles in MEMWR -> mem_write high for 4 cycles, then state returns to 0; reg_write stays 0.
- REQ-035 R-type -> state sequence 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 in state 7.
- REQ-036 beq with zero=1 -> pc_write=1 in BRANCH; bne with zero=1 -> pc_write=0; j -> pc_source=10 and pc_write=1 in JUMP.
- REQ-037 opcode 111111 -> state goes to 10, illegal=1, and stays there for 10+ cycles; reset pulse -> state=0 and illegal=0.
- REQ-038 reset asserted mid-MEMRD while mem_ready=0 -> state=0 at the next edge, with no reg_write pulse.
